// File: rtl/alu_pkg.sv
// Shared types for the handshaked sequential ALU: op codes, FSM states, filler constant.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SLL   = 4'd1,
        ALU_SLT   = 4'd2,
        ALU_SLTU  = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SRL   = 4'd5,
        ALU_OR    = 4'd6,
        ALU_AND   = 4'd7,
        ALU_SUB   = 4'd8,
        ALU_COPY  = 4'd9,
        ALU_MUL   = 4'd10,
        ALU_MULHU = 4'd11,
        ALU_DIVU  = 4'd12,
        ALU_SRA   = 4'd13,
        ALU_REMU  = 4'd14
    } alu_fun_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } alu_state_e;

    localparam logic [31:0] ALU_DEADBEEF = 32'hDEADBEEF;

    function automatic logic is_mul_op(input logic [3:0] f);
        return (f == ALU_MUL) || (f == ALU_MULHU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned mul (shift-add) / div (restoring), one result bit per cycle.
// Latency: WIDTH cycles after start; done flags the edge that completes the last step.
// No backpressure: result is only meaningful combinationally while done is high.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           op_q, op_d;
    logic [WIDTH-1:0]     x_q, x_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [WIDTH:0]       sum, diff;

    // p holds {acc_hi, multiplier} for MUL and {remainder, quotient} for DIV
    always_comb begin
        op_d  = op_q;
        x_d   = x_q;
        p_d   = p_q;
        cnt_d = cnt_q;
        sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? x_q : {WIDTH{1'b0}})};
        diff  = p_q[2*WIDTH-1:WIDTH-1] - {1'b0, x_q};
        if (start) begin
            op_d  = op;
            cnt_d = CW'(WIDTH);
            x_d   = is_mul_op(op) ? a : b;
            p_d   = {{WIDTH{1'b0}}, (is_mul_op(op) ? b : a)};
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            if (is_mul_op(op_q)) begin
                p_d = {sum, p_q[WIDTH-1:1]};
            end else if (!diff[WIDTH]) begin
                p_d = {diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
            end else begin
                p_d = {p_q[2*WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        done = (cnt_q == CW'(1));
        case (op_q)
            ALU_MUL, ALU_DIVU: result = p_d[WIDTH-1:0];
            default:           result = p_d[2*WIDTH-1:WIDTH];
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
            op_q  <= '0;
            x_q   <= '0;
            p_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            op_q  <= op_d;
            x_q   <= x_d;
            p_q   <= p_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops plus iterative MUL/MULHU/DIVU/REMU when ALU_SEQ_MULDIV_EN is defined.
// Latency: 1 cycle accept-to-out_valid for single-cycle ops, WIDTH+1 for iterative ops.
// Backpressure: RESULT/out_valid held until out_ready; in_ready only in IDLE, rising the cycle after handoff.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic [3:0]       ALU_FUN,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] RESULT,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);

    function automatic logic [WIDTH-1:0] fill_deadbeef();
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = ALU_DEADBEEF[i % 32];
        return r;
    endfunction

    localparam logic [WIDTH-1:0] DEADBEEF = fill_deadbeef();

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] alu_res;
    logic [SHW-1:0]   shamt;
    logic             accept;

    assign shamt  = srcB[SHW-1:0];
    assign accept = (state_q == IDLE) && in_ready_q && in_valid;

    always_comb begin
        case (ALU_FUN)
            ALU_ADD:  alu_res = srcA + srcB;
            ALU_SLL:  alu_res = srcA << shamt;
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
            ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (srcA < srcB)};
            ALU_XOR:  alu_res = srcA ^ srcB;
            ALU_SRL:  alu_res = srcA >> shamt;
            ALU_OR:   alu_res = srcA | srcB;
            ALU_AND:  alu_res = srcA & srcB;
            ALU_SUB:  alu_res = srcA - srcB;
            ALU_COPY: alu_res = srcA;
            ALU_SRA:  alu_res = WIDTH'($signed(srcA) >>> shamt);
`ifdef ALU_SEQ_MULDIV_EN
            // Only reached as single-cycle results on divide-by-zero (RISC-V semantics)
            ALU_DIVU: alu_res = {WIDTH{1'b1}};
            ALU_REMU: alu_res = srcA;
`endif
            default:  alu_res = DEADBEEF;
        endcase
    end

`ifdef ALU_SEQ_MULDIV_EN
    logic             md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_result;
    logic             go_iter;

    assign go_iter  = is_mul_op(ALU_FUN) ||
                      (((ALU_FUN == ALU_DIVU) || (ALU_FUN == ALU_REMU)) && (srcB != '0));
    assign md_start = accept && go_iter;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .start  (md_start),
        .op     (ALU_FUN),
        .a      (srcA),
        .b      (srcB),
        .done   (md_done),
        .result (md_result)
    );
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef ALU_SEQ_MULDIV_EN
                    if (go_iter) begin
                        state_d = BUSY;
                    end else begin
                        result_d = alu_res;
                        state_d  = DONE;
                    end
`else
                    result_d = alu_res;
                    state_d  = DONE;
`endif
                end
            end
            BUSY: begin
`ifdef ALU_SEQ_MULDIV_EN
                if (md_done) begin
                    result_d = md_result;
                    state_d  = DONE;
                end
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            result_q    <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign RESULT    = result_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=32); expectations follow ALU_SEQ_MULDIV_EN.
module tb_alu_seq;
    import alu_pkg::*;

`ifdef ALU_SEQ_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif
    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam int ILAT = MD ? 33 : 1;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] srcA, srcB;
    logic [3:0]  ALU_FUN;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] RESULT;
    logic        busy;

    alu_seq #(.WIDTH(32)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .srcA      (srcA),
        .srcB      (srcB),
        .ALU_FUN   (ALU_FUN),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .RESULT    (RESULT),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          hold;
        int          acc;
        string       nm;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic wait_ready(input string nm, output bit ok);
        int w = 0;
        @(negedge CLK);
        while (!in_ready && w < 200) begin
            @(negedge CLK);
            w++;
        end
        ok = in_ready;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s_accept: in_ready got 0 want 1 within 200 cycles", nm);
        end
    endtask

    // Drive one op; the expected response enters the scoreboard before the accept edge
    task automatic issue(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat, input int hold, input string nm);
        bit   ok;
        exp_t e;
        wait_ready(nm, ok);
        if (ok) begin
            e.res = res; e.lat = lat; e.hold = hold; e.acc = cyc + 1; e.nm = nm;
            sbq.push_back(e);
            in_valid = 1'b1; ALU_FUN = f; srcA = a; srcB = b;
            @(negedge CLK);
            in_valid = 1'b0; ALU_FUN = 4'($urandom); srcA = $urandom; srcB = $urandom;
        end
    endtask

    initial begin : monitor
        exp_t        e;
        bit          seen = 1'b0;
        int          hold = 0;
        logic [31:0] held = '0;
        out_ready = 1'b1;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                seen = 1'b0;
                out_ready = 1'b1;
            end else if (out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    hold = 0;
                    if (sbq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out: got %h want no output", RESULT);
                    end else begin
                        e = sbq.pop_front();
                        chk({e.nm, "_res"}, RESULT, e.res);
                        chk({e.nm, "_lat"}, 32'(cyc - e.acc + 1), 32'(e.lat));
                        chk({e.nm, "_busy"}, {31'b0, busy}, 32'd1);
                        hold = e.hold;
                    end
                    held = RESULT;
                end else begin
                    chk("hold_result", RESULT, held);
                    chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
                end
                if (hold > 0) begin
                    out_ready = 1'b0;
                    hold--;
                end else begin
                    out_ready = 1'b1;
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    initial begin : driver
        bit ok;
        int w;
        RST_N = 1'b0; in_valid = 1'b0; srcA = '0; srcB = '0; ALU_FUN = '0;
        repeat (3) @(negedge CLK);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", RESULT, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        issue(ALU_ADD,  32'hFFFFFFFF, 32'h1,        32'h0,        1, 0, "add_wrap");
        issue(ALU_SRA,  32'h80000000, 32'h24,       32'hF8000000, 1, 0, "sra");
        issue(ALU_SLL,  32'h1,        32'h21,       32'h2,        1, 0, "sll");
        issue(ALU_SRL,  32'h80000000, 32'h1F,       32'h1,        1, 0, "srl");
        issue(ALU_SLT,  32'hFFFFFFFF, 32'h1,        32'h1,        1, 0, "slt");
        issue(ALU_SLTU, 32'hFFFFFFFF, 32'h1,        32'h0,        1, 0, "sltu");
        issue(ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1, 0, "xor");
        issue(ALU_OR,   32'h0F0F0000, 32'h00F0F0F0, 32'h0FFFF0F0, 1, 0, "or");
        issue(ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1, 0, "and");
        issue(ALU_SUB,  32'h0,        32'h1,        32'hFFFFFFFF, 1, 0, "sub_wrap");
        issue(ALU_COPY, 32'h12345678, 32'h9,        32'h12345678, 1, 0, "copy");
        issue(4'd15,    32'h1,        32'h2,        DB,           1, 0, "illegal15");

        issue(ALU_MUL,   32'h00010000, 32'h00010000, MD ? 32'h0 : DB,        ILAT, 0, "mul");
        issue(ALU_MULHU, 32'h00010000, 32'h00010000, MD ? 32'h1 : DB,        ILAT, 0, "mulhu");
        issue(ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, MD ? 32'hFFFFFFFE : DB, ILAT, 0, "mulhu_max");
        issue(ALU_DIVU,  32'd100,      32'd7,        MD ? 32'd14 : DB,       ILAT, 0, "divu");
        issue(ALU_REMU,  32'd100,      32'd7,        MD ? 32'd2 : DB,        ILAT, 0, "remu");
        issue(ALU_DIVU,  32'h1234,     32'h0,        MD ? 32'hFFFFFFFF : DB, 1,    0, "divu_by0");
        issue(ALU_REMU,  32'd5,        32'h0,        MD ? 32'd5 : DB,        1,    0, "remu_by0");

        // Backpressure: 10 cycles of out_ready low, with stray in_valid pulses that must be ignored
        issue(ALU_ADD, 32'd3, 32'd4, 32'd7, 1, 10, "bp_add");
        repeat (4) begin
            in_valid = 1'b1; ALU_FUN = ALU_COPY; srcA = 32'hBAD0BAD0;
            @(negedge CLK);
        end
        in_valid = 1'b0;
        issue(ALU_COPY, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 1, 0, "after_bp");

`ifdef ALU_SEQ_MULDIV_EN
        // Asynchronous reset while a multiply is mid-iteration
        wait_ready("rst_busy_op", ok);
        if (ok) begin
            in_valid = 1'b1; ALU_FUN = ALU_MUL; srcA = 32'd3; srcB = 32'd5;
            @(negedge CLK);
            in_valid = 1'b0;
            repeat (5) @(negedge CLK);
            chk("midbusy_busy", {31'b0, busy}, 32'd1);
            RST_N = 1'b0;
            #1;
            chk("midbusy_out_valid", {31'b0, out_valid}, 32'd0);
            chk("midbusy_result", RESULT, 32'd0);
            chk("midbusy_busy_rst", {31'b0, busy}, 32'd0);
            @(negedge CLK);
            RST_N = 1'b1;
            @(negedge CLK);
            chk("midbusy_in_ready", {31'b0, in_ready}, 32'd1);
        end
        issue(ALU_MUL, 32'd3, 32'd5, 32'd15, 33, 0, "mul_after_rst");
`else
        issue(ALU_ADD, 32'd3, 32'd5, 32'd8, 1, 0, "add_tail");
`endif

        w = 0;
        while ((sbq.size() != 0 || out_valid) && w < 500) begin
            @(negedge CLK);
            w++;
        end
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d outstanding want 0", sbq.size());
        end
        repeat (5) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
